// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between the instruction memory port
// and decode. It runs sequential word fetches ahead of decode and reserves one
// slot per accepted request. Responses fill slots in order, and decode pops
// them in order. A redirect flushes every slot and restarts fetch at the new
// PC. Responses that are still owed for requests issued before the flush are
// counted and then discarded when they arrive.
//
// Ports:
//   clk_i, reset_i                    clock, synchronous active-high reset
//   imem_req_valid_o/addr_o/ready_i   fetch request handshake
//   imem_rsp_valid_i/data_i           in-order fetch responses
//   instr_valid_o/instr_o/instr_pc_o  head entry offered to decode
//   instr_ready_i                     decode consumes head
//   redirect_valid_i/redirect_pc_i    flush and restart fetch
//   occupancy_o                       reserved slots (in flight + filled)
module fetch_queue #(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  output logic                         imem_req_valid_o,
  output logic [ADDR_WIDTH-1:0]        imem_req_addr_o,
  input  logic                         imem_req_ready_i,
  input  logic                         imem_rsp_valid_i,
  input  logic [31:0]                  imem_rsp_data_i,
  output logic                         instr_valid_o,
  output logic [31:0]                  instr_o,
  output logic [ADDR_WIDTH-1:0]        instr_pc_o,
  input  logic                         instr_ready_i,
  input  logic                         redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc_i,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  // Stale responses can pile up across back-to-back redirects, so the drop
  // counter gets headroom beyond a single queue's worth.
  localparam int DW = OW + 4;
  localparam logic [OW-1:0]         DEPTH_C  = OW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RST_ADDR = RESET_PC & ~ADDR_WIDTH'(3);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic                  filled;
  } slot_t;

  slot_t                 slots [DEPTH];
  logic [PW-1:0]         alloc_ptr, fill_ptr, head_ptr;
  logic [OW-1:0]         occ;
  // Requests accepted but not yet answered. This is tracked as its own count
  // because alloc and fill are equal both when the queue is empty and when
  // every slot is in flight.
  logic [OW-1:0]         infl;
  logic [DW-1:0]         drop_cnt;
  logic [ADDR_WIDTH-1:0] fetch_pc;

  logic          req_fire, rsp_keep, rsp_drop, pop;
  logic [DW:0]   drop_sum;
  logic [DW-1:0] drop_next;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  // The credit check uses registered occupancy, so a pop does not free a slot
  // for a request in the same cycle.
  assign imem_req_valid_o = (occ < DEPTH_C) && !redirect_valid_i && !reset_i;
  assign imem_req_addr_o  = reset_i ? '0 : fetch_pc;
  assign instr_valid_o    = slots[head_ptr].filled && (occ != '0) &&
                            !redirect_valid_i && !reset_i;
  assign instr_o          = reset_i ? '0 : slots[head_ptr].instr;
  assign instr_pc_o       = reset_i ? '0 : slots[head_ptr].pc;
  assign occupancy_o      = reset_i ? '0 : occ;

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign pop      = instr_valid_o && instr_ready_i;
  // A response with nothing in flight and nothing to drop breaks the protocol
  // and is ignored.
  assign rsp_keep = imem_rsp_valid_i && (drop_cnt == '0) && (infl != '0);
  assign rsp_drop = imem_rsp_valid_i && (drop_cnt != '0);

  // On a redirect, every in-flight request becomes stale. A response arriving
  // in the redirect cycle is also thrown away. If it was still owed to the old
  // drop count, it retires one of those. Otherwise it retires the oldest
  // in-flight request. Either way, it lowers the total by one, floored at 0.
  always_comb begin
    drop_sum  = {1'b0, drop_cnt} + (DW+1)'(infl);
    drop_next = '0;
    if (imem_rsp_valid_i && (drop_sum != '0))
      drop_sum = drop_sum - (DW+1)'(1);
    if (drop_sum[DW]) drop_next = '1;
    else              drop_next = drop_sum[DW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occ       <= '0;
      infl      <= '0;
      drop_cnt  <= '0;
      fetch_pc  <= RST_ADDR;
      for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
    end else if (redirect_valid_i) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occ       <= '0;
      infl      <= '0;
      drop_cnt  <= drop_next;
      fetch_pc  <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
    end else begin
      // alloc and fill cannot point at the same slot here. When they are
      // equal, either nothing is in flight (no fill) or the queue is full
      // (no request).
      if (req_fire) begin
        slots[alloc_ptr].pc     <= fetch_pc;
        slots[alloc_ptr].filled <= 1'b0;
        alloc_ptr               <= alloc_ptr + PW'(1);
        fetch_pc                <= fetch_pc + ADDR_WIDTH'(4);
      end
      if (rsp_keep) begin
        slots[fill_ptr].instr  <= imem_rsp_data_i;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
      if (pop)      head_ptr <= head_ptr + PW'(1);
      occ  <= occ  + OW'(req_fire) - OW'(pop);
      infl <= infl + OW'(req_fire) - OW'(rsp_keep);
    end
  end
endmodule
